donut_march_ctl: RTL and testbench

Sequencer for the `donuthit` ray-marching datapath. It accepts one ray request at a time over a valid/ready handshake and pulses `dh_start` so the datapath latches the ray. It then counts the fixed number of march iterations, captures the hit flag and light intensity, and converts them to an 8-bit shade. The result, with the request's tag, is returned over a second valid/ready handshake. It sits between the per-pixel ray generator and the scanline writer; ray origin, direction and light vectors go straight from the generator to `donuthit` and do not pass through this block.

---
 rtl/donut_march_ctl.sv | 117 +++++++++++
 tb/tb_donut_march_ctl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/donut_march_ctl.sv
// Ray sequencer for the donuthit datapath: accepts a ray, marches STEPS cycles, returns a shade.
// Optional macro DONUT_MARCH_EARLY_EXIT_EN ends the march on the first observed miss.
module donut_march_ctl #(
  parameter int unsigned STEPS   = 8,
  parameter int unsigned TAG_W   = 10,
  parameter logic [7:0]  BG      = 8'd0,
  parameter logic [7:0]  AMBIENT = 8'd16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                dh_start,
  input  logic                dh_hit,
  input  logic signed [15:0]  dh_light,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [TAG_W-1:0]    res_tag,
  output logic                res_hit,
  output logic [7:0]          res_shade,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StMarch, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [TAG_W-1:0]   r_req_tag;
  logic [TAG_W-1:0]   r_res_tag;
  logic               r_res_hit;
  logic [7:0]         r_res_shade;
  logic               w_accept;
  logic               w_capture;
  logic [16:0]        w_lpos;
  logic [16:0]        w_sum;
  logic [7:0]         w_shade;

  // Negative light clamps to zero; 17 bits cannot overflow with AMBIENT added.
  always_comb begin
    w_lpos  = dh_light[15] ? 17'd0 : {1'b0, dh_light};
    w_sum   = {9'd0, AMBIENT} + (w_lpos >> 1);
    w_shade = BG;
    if (dh_hit) begin
      w_shade = (w_sum > 17'd255) ? 8'hFF : w_sum[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 8'(STEPS);
          w_state_nxt = StMarch;
        end
      end
      StMarch: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_capture = 1'b1;
        end
`ifdef DONUT_MARCH_EARLY_EXIT_EN
        // A miss is final within a ray, so stopping now gives the same result sooner.
        if (!dh_hit) begin
          w_capture = 1'b1;
        end
`endif
        if (w_capture) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_req_tag   <= '0;
      r_res_tag   <= '0;
      r_res_hit   <= 1'b0;
      r_res_shade <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_req_tag <= req_tag;
      end
      if (w_capture) begin
        r_res_tag   <= r_req_tag;
        r_res_hit   <= dh_hit;
        r_res_shade <= w_shade;
      end
    end
  end

  // Handshake outputs are held low while reset is asserted.
  assign req_ready = rst_n && (r_state == StIdle);
  assign dh_start  = rst_n && w_accept;
  assign res_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign res_tag   = r_res_tag;
  assign res_hit   = r_res_hit;
  assign res_shade = r_res_shade;

endmodule

// File: tb/tb_donut_march_ctl.sv
// Self-checking bench for donut_march_ctl: timestamp-based reference model plus directed rays.
module tb_donut_march_ctl;

  localparam int unsigned STEPS = 8;
`ifdef DONUT_MARCH_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [9:0]         req_tag;
  logic               dh_start;
  logic               dh_hit;
  logic signed [15:0] dh_light;
  logic               res_valid;
  logic               res_ready;
  logic [9:0]         res_tag;
  logic               res_hit;
  logic [7:0]         res_shade;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat;

  donut_march_ctl #(
    .STEPS   (STEPS),
    .TAG_W   (10),
    .BG      (8'd0),
    .AMBIENT (8'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .dh_start  (dh_start),
    .dh_hit    (dh_hit),
    .dh_light  (dh_light),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_tag   (res_tag),
    .res_hit   (res_hit),
    .res_shade (res_shade),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int shade_of(input logic hit, input logic signed [15:0] light);
    int l;
    int s;
    if (!hit) return 0;
    l = (light < 0) ? 0 : int'(light);
    s = 16 + l / 2;
    return (s > 255) ? 255 : s;
  endfunction

  // Reference model: a ray is busy from acceptance until popped; the result is due
  // STEPS cycles after the acceptance cycle (or at the first miss when early exit is on).
  bit         m_busy, m_done;
  int         m_acc_cyc;
  logic [9:0] m_tag_pend, m_res_tag;
  logic       m_res_hit;
  int         m_res_shade;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_done      <= 1'b0;
      m_acc_cyc   <= 0;
      m_tag_pend  <= '0;
      m_res_tag   <= '0;
      m_res_hit   <= 1'b0;
      m_res_shade <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy     <= 1'b1;
        m_acc_cyc  <= cyc;
        m_tag_pend <= req_tag;
      end
    end else if (!m_done) begin
      if (cyc == m_acc_cyc + int'(STEPS) || (EARLY && !dh_hit)) begin
        m_done      <= 1'b1;
        m_res_tag   <= m_tag_pend;
        m_res_hit   <= dh_hit;
        m_res_shade <= shade_of(dh_hit, dh_light);
      end
    end else if (res_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, rst_n && !m_busy);
    chk("dh_start", dh_start, rst_n && !m_busy && req_valid);
    chk("res_valid", res_valid, m_done);
    chk("busy", busy, m_busy);
    chk("res_tag", res_tag, m_res_tag);
    chk("res_hit", res_hit, m_res_hit);
    chk("res_shade", res_shade, m_res_shade);
  end

  // Called just after a rising edge; returns just after the pop edge (block idle again).
  task automatic run_ray(input logic [9:0] tag, input logic signed [15:0] light,
                         input int drop_cyc, input int hold_cyc, input bit keep_valid,
                         output int latency);
    req_valid = 1'b1;
    req_tag   = tag;
    dh_light  = light;
    dh_hit    = 1'b1;
    @(negedge clk);
    chk("start_cycle0", dh_start, 1);
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    latency = -1;
    for (int k = 1; k <= 40 && latency < 0; k++) begin
      if (k == drop_cyc) dh_hit = 1'b0;
      @(negedge clk);
      chk("start_low_march", dh_start, 0);
      if (res_valid) latency = k;
      else begin
        @(posedge clk); #1;
      end
    end
    if (latency < 0) chk("res_valid_timeout", 0, 1);
    for (int h = 0; h < hold_cyc; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_ready_low", req_ready, 0);
      chk("hold_tag_stable", res_tag, tag);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_tag   = '0;
    dh_hit    = 1'b1;
    dh_light  = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_shade", res_shade, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    run_ray(10'h155, 16'sd200, -1, 0, 1'b0, lat);
    chk("lat_hit", lat, 9);
    chk("t1_tag", res_tag, 10'h155);
    chk("t1_hit", res_hit, 1);
    chk("t1_shade", res_shade, 116);

    run_ray(10'h0A1, -16'sd50, -1, 0, 1'b0, lat);
    chk("neg_light_shade", res_shade, 16);
    run_ray(10'h0A2, 16'sd600, -1, 0, 1'b0, lat);
    chk("sat_shade", res_shade, 255);

    run_ray(10'h0A3, 16'sd300, 2, 0, 1'b0, lat);
    chk("miss_latency", lat, EARLY ? 3 : 9);
    chk("miss_hit", res_hit, 0);
    chk("miss_shade", res_shade, 0);

    // Back-pressure with the generator holding req_valid; re-accept follows the pop.
    run_ray(10'h2AA, 16'sd100, -1, 20, 1'b1, lat);
    chk("bp_shade", res_shade, 66);
    run_ray(10'h3C3, 16'sd10, -1, 0, 1'b0, lat);
    chk("after_bp_lat", lat, 9);
    chk("after_bp_shade", res_shade, 21);

    // Reset in MARCH cycle 4 discards the ray.
    req_valid = 1'b1;
    req_tag   = 10'h0F0;
    dh_light  = 16'sd200;
    dh_hit    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_res_tag", res_tag, 0);
    chk("arst_res_hit", res_hit, 0);
    chk("arst_res_shade", res_shade, 0);
    chk("arst_dh_start", dh_start, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_result_after_rst", res_valid, 0);
    end
    @(posedge clk); #1;
    run_ray(10'h111, 16'sd40, -1, 0, 1'b0, lat);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_tag", res_tag, 10'h111);
    chk("post_rst_shade", res_shade, 36);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
